// File: rtl/alu_seq_pkg.sv
// Shared encodings for the sliced Y86 ALU sequencer: function codes, FSM states,
// condition-code bit positions and the latched request record.
package alu_seq_pkg;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_XOR = 4'h3;

  localparam int CC_ZF = 2;
  localparam int CC_SF = 1;
  localparam int CC_OF = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0]  fun;
    logic [63:0] a;
    logic [63:0] b;
  } alu_req_t;

  function automatic logic is_arith(input logic [3:0] fun);
    return (fun == ALU_ADD) || (fun == ALU_SUB);
  endfunction

endpackage

// File: rtl/alu_slice.sv
// One SLICE_W-bit adder/logic slice. Subtraction arrives pre-inverted with cin=1,
// so add and sub share the adder; logic ops pass the carry through untouched.
module alu_slice
  import alu_seq_pkg::*;
#(
  parameter int SLICE_W = 16
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  input  logic [3:0]         fun,
  output logic [SLICE_W-1:0] y,
  output logic               cout
);

  logic [SLICE_W:0] sum;
  assign sum = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, cin};

  always_comb begin
    y    = '0;
    cout = cin;
    case (fun)
      ALU_ADD, ALU_SUB: begin
        y    = sum[SLICE_W-1:0];
        cout = sum[SLICE_W];
      end
      ALU_AND: y = a & b;
      ALU_XOR: y = a ^ b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_slice_sequencer.sv
// Multi-cycle Y86 ALU: walks one alu_slice across 64/SLICE_W slices, LSB first.
// Optional ALU_SEQ_ABORT_EN adds an abort input that flushes RUN/DONE to IDLE.
module alu_slice_sequencer
  import alu_seq_pkg::*;
#(
  parameter int SLICE_W = 16
) (
  input  logic        clk,
  input  logic        rst,
`ifdef ALU_SEQ_ABORT_EN
  input  logic        abort,
`endif
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_fun,
  input  logic [63:0] req_a,
  input  logic [63:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_result,
  output logic [2:0]  rsp_cc,
  output logic        rsp_err
);

  localparam int N  = 64 / SLICE_W;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  state_t            state;
  logic [IW-1:0]     idx;
  logic              carry;
  alu_req_t          op;
  logic [63:0]       res;
  logic [63:0]       res_nxt;
  logic [5:0]        base;
  logic [SLICE_W-1:0] slice_y;
  logic              slice_cout;
  logic              last;
  logic              op_err;
  logic              of_nxt;
  logic [2:0]        cc_nxt;
  logic              flush;

`ifdef ALU_SEQ_ABORT_EN
  assign flush = abort;
`else
  assign flush = 1'b0;
`endif

  assign base = 6'(idx) * 6'(SLICE_W);
  assign last = (idx == IW'(N - 1));

  alu_slice #(.SLICE_W(SLICE_W)) u_slice (
    .a    (op.a[base +: SLICE_W]),
    .b    (op.b[base +: SLICE_W]),
    .cin  (carry),
    .fun  (op.fun),
    .y    (slice_y),
    .cout (slice_cout)
  );

  always_comb begin
    res_nxt                   = res;
    res_nxt[base +: SLICE_W]  = slice_y;
  end

  // op.a already holds ~valA for sub, so one OF expression covers add and sub.
  assign op_err = (op.fun > ALU_XOR);
  assign of_nxt = is_arith(op.fun) && (op.a[63] == op.b[63]) && (res_nxt[63] != op.b[63]);
  assign cc_nxt = op_err ? 3'b000 : {(res_nxt == 64'd0), res_nxt[63], of_nxt};

  assign req_ready  = (state == IDLE);
  assign rsp_valid  = (state == DONE);
  assign rsp_result = res;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      carry   <= 1'b0;
      op      <= '0;
      res     <= '0;
      rsp_cc  <= '0;
      rsp_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          op.fun <= req_fun;
          op.a   <= (req_fun == ALU_SUB) ? ~req_a : req_a;
          op.b   <= req_b;
          carry  <= (req_fun == ALU_SUB);
          res    <= '0;
          idx    <= '0;
          state  <= RUN;
        end
        RUN: if (flush) begin
          state   <= IDLE;
          idx     <= '0;
          res     <= '0;
          rsp_cc  <= '0;
          rsp_err <= 1'b0;
        end else begin
          res   <= res_nxt;
          carry <= slice_cout;
          idx   <= idx + 1'b1;
          if (last) begin
            idx     <= '0;
            rsp_cc  <= cc_nxt;
            rsp_err <= op_err;
            state   <= DONE;
          end
        end
        DONE: if (flush) begin
          state   <= IDLE;
          res     <= '0;
          rsp_cc  <= '0;
          rsp_err <= 1'b0;
        end else if (rsp_ready) begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_slice_sequencer.sv
// Self-checking bench for alu_slice_sequencer (SLICE_W=16): directed table,
// random ops against an arithmetic model, backpressure and mid-run reset.
module tb_alu_slice_sequencer;

  localparam int SLICE_W = 16;
  localparam int N       = 64 / SLICE_W;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        abort = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_fun = 4'h0;
  logic [63:0] req_a = 64'd0;
  logic [63:0] req_b = 64'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_result;
  logic [2:0]  rsp_cc;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_slice_sequencer #(.SLICE_W(SLICE_W)) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef ALU_SEQ_ABORT_EN
    .abort      (abort),
`endif
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_fun    (req_fun),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_cc     (rsp_cc),
    .rsp_err    (rsp_err)
  );

  typedef struct {
    logic [3:0]  fun;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] r;
    logic [2:0]  cc;
    logic        err;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: Y86 semantics with whole-word arithmetic.
  function automatic void model(input logic [3:0] fun, input logic [63:0] a, input logic [63:0] b,
                                output logic [63:0] r, output logic [2:0] cc, output logic err);
    logic of;
    of  = 1'b0;
    err = 1'b0;
    case (fun)
      4'h0: begin r = b + a; of = (a[63] == b[63]) && (r[63] != a[63]); end
      4'h1: begin r = b - a; of = (b[63] != a[63]) && (r[63] != b[63]); end
      4'h2: r = a & b;
      4'h3: r = a ^ b;
      default: begin r = 64'd0; err = 1'b1; end
    endcase
    cc = err ? 3'b000 : {r == 64'd0, r[63], of};
  endfunction

  // Issue one op and wait for the response without acknowledging it.
  task automatic issue(input logic [3:0] fun, input logic [63:0] a, input logic [63:0] b,
                       output int lat);
    int cyc;
    cyc = 0;
    while (!req_ready && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    if (!req_ready) begin
      errors++; checks++;
      $display("FAIL req_ready_timeout got=0 expected=1");
    end
    req_valid = 1'b1; req_fun = fun; req_a = a; req_b = b;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("idle_after_ack", {62'd0, req_ready, rsp_valid}, 64'd2);
  endtask

  task automatic run_op(input string name, input logic [3:0] fun, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] er, input logic [2:0] ecc,
                        input logic eerr);
    int lat;
    issue(fun, a, b, lat);
    chk({name, "_latency"}, 64'(lat), 64'(N));
    chk({name, "_result"}, rsp_result, er);
    chk({name, "_cc"}, 64'(rsp_cc), 64'(ecc));
    chk({name, "_err"}, 64'(rsp_err), 64'(eerr));
    ack();
  endtask

  vec_t vecs[9];

  initial begin
    logic [63:0] er, ra, rb;
    logic [2:0]  ecc;
    logic        eerr;
    logic [3:0]  rf;
    logic        seen_valid;
    int          lat;

    vecs[0] = '{4'h0, 64'd5, 64'd3, 64'd8, 3'b000, 1'b0};
    vecs[1] = '{4'h0, 64'h000000000000FFFF, 64'd1, 64'h0000000000010000, 3'b000, 1'b0};
    vecs[2] = '{4'h0, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFE, 3'b010, 1'b0};
    vecs[3] = '{4'h0, 64'h7FFFFFFFFFFFFFFF, 64'h7FFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFE, 3'b011, 1'b0};
    vecs[4] = '{4'h1, 64'd1, 64'd0, 64'hFFFFFFFFFFFFFFFF, 3'b010, 1'b0};
    vecs[5] = '{4'h1, 64'h1234, 64'h1234, 64'd0, 3'b100, 1'b0};
    vecs[6] = '{4'h2, 64'hF0, 64'h0F, 64'd0, 3'b100, 1'b0};
    vecs[7] = '{4'h3, 64'hAA, 64'hAA, 64'd0, 3'b100, 1'b0};
    vecs[8] = '{4'h7, 64'h1234, 64'h5678, 64'd0, 3'b000, 1'b1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hs", {62'd0, req_ready, rsp_valid}, 64'd2);
    chk("reset_result", rsp_result, 64'd0);
    chk("reset_cc_err", {60'd0, rsp_cc, rsp_err}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++)
      run_op($sformatf("vec%0d", i), vecs[i].fun, vecs[i].a, vecs[i].b,
             vecs[i].r, vecs[i].cc, vecs[i].err);

    // Random ops against the model
    for (int i = 0; i < 40; i++) begin
      rf = (i % 8 == 7) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (i % 5 == 0) ra = ~rb + ((i % 10 == 0) ? 64'd1 : 64'd0);
      if (i % 7 == 3) begin ra = 64'h8000000000000000; rb = {1'b0, 63'(rb)}; end
      model(rf, ra, rb, er, ecc, eerr);
      run_op($sformatf("rand%0d", i), rf, ra, rb, er, ecc, eerr);
    end

    // Backpressure: response must hold while rsp_ready is low
    issue(4'h0, 64'd5, 64'd3, lat);
    chk("bp_latency", 64'(lat), 64'(N));
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp_hold%0d", c), {rsp_result[59:0], rsp_cc, rsp_valid},
          {60'd8, 3'b000, 1'b1});
      chk($sformatf("bp_ready%0d", c), 64'(req_ready), 64'd0);
      @(posedge clk); #1;
    end
    ack();

    // Reset mid-RUN at idx=2: drop op asynchronously, no response afterwards
    req_valid = 1'b1; req_fun = 4'h0;
    req_a = 64'h1111111111111111; req_b = 64'h2222222222222222;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("pre_rst_partial", 64'(rsp_result != 64'd0), 64'd1);
    rst = 1'b1;
    #1;
    chk("rst_async_result", rsp_result, 64'd0);
    chk("rst_async_hs", {62'd0, req_ready, rsp_valid}, 64'd2);
    chk("rst_async_cc", {60'd0, rsp_cc, rsp_err}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen_valid = 1'b1;
    end
    chk("rst_no_response", 64'(seen_valid), 64'd0);
    run_op("post_rst", 4'h0, 64'd5, 64'd3, 64'd8, 3'b000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_slice_sequencer.md
Name: alu_slice_sequencer

Overview:
Multi-cycle Y86 ALU execute engine that reuses one SLICE_W-bit adder/logic slice over 64/SLICE_W cycles instead of a full 64-bit ripple chain.
- Accepts one operation at a time from the execute stage over a valid/ready handshake.
- Sequences the slices least-significant first with a registered carry.
- Returns valE and condition codes (ZF, SF, OF) over a second valid/ready handshake.

Parameters:
SLICE_W, 16, slice width in bits; legal values are 1, 2, 4, 8, 16, 32, 64. N = 64/SLICE_W cycles per operation.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  operation offered
req_ready  out  1  engine can accept (state IDLE)
req_fun  in  4  Y86 ifun: 0 add, 1 sub, 2 and, 3 xor
req_a  in  64  valA
req_b  in  64  valB
rsp_valid  out  1  result available (state DONE)
rsp_ready  in  1  consumer takes result
rsp_result  out  64  valE = valB OP valA (sub computes valB - valA)
rsp_cc  out  3  {ZF, SF, OF}
rsp_err  out  1  req_fun was > 3

Behaviour:
- Reset (async, while rst=1): state IDLE, idx 0, carry 0, result register 0, rsp_valid 0, rsp_result 0, rsp_cc 0, rsp_err 0. req_valid is ignored while rst=1.
- req_ready = (state==IDLE); rsp_valid = (state==DONE). Both are pure state decodes.
- IDLE: on req_valid && req_ready, latch the operands and go to RUN with idx=0:
  - sub: latch a=~req_a, carry=1.
  - add, and, xor: latch a=req_a, carry=0.
  - Latch b=req_b and fun.
  - Clear result.
- RUN, each cycle, on slice idx:
  - add/sub: result[idx] = b + a + carry; carry <= slice carry-out.
  - and/xor: bitwise result; carry is unchanged.
  - idx increments each cycle. At idx==N-1, go to DONE and compute cc from the complete result.
- Latency: the accept edge is edge 0. rsp_valid is high after edge N; for SLICE_W=64 that is one cycle.
- cc rules:
  - ZF = (result==0); SF = result[63].
  - OF for add: a63==b63 && r63!=a63.
  - OF for sub: b63!=req_a63 && r63!=b63.
  - OF = 0 for and/xor.
- fun > 3: still takes N cycles. Result 0, cc 000, rsp_err 1.
- DONE: rsp_result, rsp_cc and rsp_err stay stable until rsp_valid && rsp_ready, then go to IDLE. rsp_result is held until the next accept.
- No overlap: a new request cannot be accepted in the same cycle as the response handshake. Throughput is one op per N+2 cycles with rsp_ready tied to 1.
- Carry out of bit 63 is discarded; results wrap modulo 2^64.
- rst asserted mid-RUN or in DONE: the operation is dropped immediately, with no response.

Optional Feature:
ALU_SEQ_ABORT_EN:
- When defined, adds input port abort (1 bit), used for mispredict/flush.
- abort=1 in RUN or DONE: next edge goes to IDLE, rsp_valid drops, and result and cc clear to 0.
- abort in IDLE is ignored. If abort and rsp_ready are both high in DONE, abort wins and no handshake is counted.
- When undefined, the port is absent and every accepted operation completes.

Decomposition:
- Package alu_seq_pkg holds:
  - fun codes ALU_ADD=4'h0, ALU_SUB=4'h1, ALU_AND=4'h2, ALU_XOR=4'h3;
  - state encoding IDLE/RUN/DONE;
  - CC bit indices CC_ZF=2, CC_SF=1, CC_OF=0.
- One combinational sub-module, alu_slice: inputs SLICE_W-wide a, b, cin, fun; outputs y, cout. The top level holds the FSM, idx counter, carry and result registers.

Test Plan:
- SLICE_W=16, add a=5, b=3: rsp_valid after exactly 4 cycles, result 8, cc 000, err 0.
- Slice carry propagation, add a=0x000000000000FFFF, b=1: result 0x0000000000010000. With a=b=0xFFFFFFFFFFFFFFFF: result 0xFFFFFFFFFFFFFFFE, SF=1, OF=0.
- Overflow:
  - add a=b=0x7FFFFFFFFFFFFFFF: result 0xFFFFFFFFFFFFFFFE, cc 011.
  - sub a=1, b=0: result 0xFFFFFFFFFFFFFFFF, cc 010.
  - sub a=b=0x1234: result 0, cc 100.
- and a=0xF0, b=0x0F: result 0, cc 100. xor a=b=0xAA: result 0, cc 100. fun=7: result 0, cc 000, err 1.
- Backpressure: hold rsp_ready=0 for 5 cycles in DONE. rsp_valid, result and cc stay stable and req_ready stays 0. Then rsp_ready=1 gives IDLE next edge.
- Reset: pulse rst mid-RUN (idx=2). Outputs go to 0 asynchronously, no response is produced, and the next add completes normally.
